// File: rtl/cal_pkg.sv
// Shared types and sizing helpers for the calibration offset sequencer.
package cal_pkg;

  // Capture sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ACCUM,
    DONE,
    ERROR
  } cal_state_t;

  // Bits needed for a counter that must hold values 0..max_count (never 0 bits wide).
  function automatic int cnt_w(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/cal_offset_corrector.sv
// Registered saturating offset subtract on the live sample stream.
// One clock of latency, accepts a new sample every cycle.
module cal_offset_corrector #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] offset,
  output logic              corr_valid,
  output logic [DATA_W-1:0] corr_data
);

  logic              no_underflow;
  logic [DATA_W-1:0] difference;

  // Raw difference and the underflow test that selects clamping to zero.
  always_comb begin
    no_underflow = (sample_data >= offset);
    difference   = sample_data - offset;
  end

  // Register the corrected sample; the data holds while no new sample arrives.
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values and the result does not depend on statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      corr_valid <= 1'b0;
      corr_data  <= '0;
    end else begin
      corr_valid <= sample_valid;
      if (sample_valid) begin
        corr_data <= no_underflow ? difference : '0;
      end
    end
  end

endmodule

// File: rtl/cal_offset_sequencer.sv
// Zero-offset calibration: on a calibration pulse, discard settling samples,
// average a power-of-two block of ADC samples and keep the result as the
// offset, which is subtracted (saturating) from the live sample stream.
module cal_offset_sequencer #(
  parameter int DATA_W         = 16,
  parameter int AVG_LOG2       = 4,
  parameter int SETTLE_SAMPLES = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cal_pulse,
  input  logic              clr_pulse,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic [DATA_W-1:0] offset,
  output logic              cal_valid,
  output logic              busy,
  output logic              cal_error,
  output logic              corr_valid,
  output logic [DATA_W-1:0] corr_data
);

  import cal_pkg::*;

  localparam int SET_W = cnt_w(SETTLE_SAMPLES);
  localparam int TMO_W = cnt_w(TIMEOUT_CYCLES);
  localparam int ACC_W = DATA_W + AVG_LOG2;   // wide enough that the sum never overflows
  localparam int NUM_W = AVG_LOG2 + 1;        // one spare bit keeps AVG_LOG2 = 0 legal
  localparam logic [NUM_W-1:0] LAST_SAMPLE = NUM_W'((1 << AVG_LOG2) - 1);

  cal_state_t        state,        state_nxt;
  logic [SET_W-1:0]  settle_cnt,   settle_nxt;
  logic [TMO_W-1:0]  tmo_cnt,      tmo_nxt;
  logic [ACC_W-1:0]  acc,          acc_nxt;
  logic [NUM_W-1:0]  num_cnt,      num_nxt;
  logic [DATA_W-1:0] offset_nxt;
  logic              cal_valid_nxt;
  logic              cal_error_nxt;
  logic              busy_nxt;
  logic              settle_last;
  logic              tmo_expired;

  // Event decodes: last settle sample, and a silent clock that would hit the timeout.
  always_comb begin
    settle_last = (32'(settle_cnt) + 32'd1 >= 32'(SETTLE_SAMPLES));
    tmo_expired = (32'(tmo_cnt) + 32'd1 >= 32'(TIMEOUT_CYCLES));
  end

  // Next-state and next-value logic; clear overrides everything else.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    settle_nxt    = settle_cnt;
    tmo_nxt       = tmo_cnt;
    acc_nxt       = acc;
    num_nxt       = num_cnt;
    offset_nxt    = offset;
    cal_valid_nxt = cal_valid;
    cal_error_nxt = cal_error;

    if (clr_pulse) begin
      state_nxt     = IDLE;
      settle_nxt    = '0;
      tmo_nxt       = '0;
      acc_nxt       = '0;
      num_nxt       = '0;
      offset_nxt    = '0;
      cal_valid_nxt = 1'b0;
      cal_error_nxt = 1'b0;
    end else begin
      unique case (state)
        // ERROR behaves like IDLE, except cal_error stays set until a capture completes.
        IDLE, ERROR: begin
          if (cal_pulse) begin
            settle_nxt = '0;
            tmo_nxt    = '0;
            acc_nxt    = '0;
            num_nxt    = '0;
            state_nxt  = (SETTLE_SAMPLES == 0) ? ACCUM : SETTLE;
          end
        end

        SETTLE: begin
          if (sample_valid) begin
            tmo_nxt    = '0;
            settle_nxt = settle_cnt + SET_W'(1);
            if (settle_last) begin
              acc_nxt   = '0;
              num_nxt   = '0;
              state_nxt = ACCUM;
            end
          end else if (tmo_expired) begin
            cal_error_nxt = 1'b1;
            state_nxt     = ERROR;
          end else begin
            tmo_nxt = tmo_cnt + TMO_W'(1);
          end
        end

        ACCUM: begin
          if (sample_valid) begin
            tmo_nxt = '0;
            acc_nxt = acc + ACC_W'(sample_data);
            num_nxt = num_cnt + NUM_W'(1);
            if (num_cnt == LAST_SAMPLE) begin
              state_nxt = DONE;
            end
          end else if (tmo_expired) begin
            cal_error_nxt = 1'b1;
            state_nxt     = ERROR;
          end else begin
            tmo_nxt = tmo_cnt + TMO_W'(1);
          end
        end

        // acc already includes the final sample; publish the truncated mean.
        DONE: begin
          offset_nxt    = DATA_W'(acc >> AVG_LOG2);
          cal_valid_nxt = 1'b1;
          cal_error_nxt = 1'b0;
          state_nxt     = IDLE;
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt == SETTLE) || (state_nxt == ACCUM);
  end

  // State, counters, accumulator and published calibration registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      acc        <= '0;
      num_cnt    <= '0;
      offset     <= '0;
      cal_valid  <= 1'b0;
      cal_error  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      tmo_cnt    <= tmo_nxt;
      acc        <= acc_nxt;
      num_cnt    <= num_nxt;
      offset     <= offset_nxt;
      cal_valid  <= cal_valid_nxt;
      cal_error  <= cal_error_nxt;
      busy       <= busy_nxt;
    end
  end

  // Live correction uses whatever offset is registered when each sample arrives.
  cal_offset_corrector #(
    .DATA_W (DATA_W)
  ) u_corrector (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .offset       (offset),
    .corr_valid   (corr_valid),
    .corr_data    (corr_data)
  );

endmodule

// File: tb/tb_cal_offset_sequencer.sv
// Self-checking bench for cal_offset_sequencer: directed scenarios plus a
// randomized run, all checked cycle by cycle against a sample-list model.
module tb_cal_offset_sequencer;

  localparam int DATA_W         = 16;
  localparam int AVG_LOG2       = 4;
  localparam int SETTLE_SAMPLES = 4;
  localparam int TIMEOUT_CYCLES = 50;
  localparam int AVG_N          = 1 << AVG_LOG2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cal_pulse;
  logic              clr_pulse;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [DATA_W-1:0] offset;
  logic              cal_valid;
  logic              busy;
  logic              cal_error;
  logic              corr_valid;
  logic [DATA_W-1:0] corr_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cal_offset_sequencer #(
    .DATA_W         (DATA_W),
    .AVG_LOG2       (AVG_LOG2),
    .SETTLE_SAMPLES (SETTLE_SAMPLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cal_pulse    (cal_pulse),
    .clr_pulse    (clr_pulse),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .offset       (offset),
    .cal_valid    (cal_valid),
    .busy         (busy),
    .cal_error    (cal_error),
    .corr_valid   (corr_valid),
    .corr_data    (corr_data)
  );

  // Reference model: a capture is the list of valid samples seen since the
  // accepted pulse; once it holds settle + block samples, one more clock
  // publishes the mean of the block part.
  bit m_capturing;
  bit m_done_pending;
  bit m_error;
  bit m_cal_valid;
  bit m_corr_valid;
  int m_offset;
  int m_corr_data;
  int m_quiet;
  int m_samples[$];

  function automatic int block_mean();
    longint sum = 0;
    for (int i = SETTLE_SAMPLES; i < SETTLE_SAMPLES + AVG_N; i++) sum += m_samples[i];
    return int'(sum / AVG_N);
  endfunction

  task automatic model_reset();
    m_capturing    = 0;
    m_done_pending = 0;
    m_error        = 0;
    m_cal_valid    = 0;
    m_corr_valid   = 0;
    m_offset       = 0;
    m_corr_data    = 0;
    m_quiet        = 0;
    m_samples.delete();
  endtask

  // Drive one clock of stimulus, advance the model, and compare all outputs.
  task automatic step(input bit cal, input bit clr, input bit v, input logic [DATA_W-1:0] d);
    cal_pulse    = cal;
    clr_pulse    = clr;
    sample_valid = v;
    sample_data  = d;
    if (!reset_n) begin
      model_reset();
    end else begin
      m_corr_valid = v;
      if (v) m_corr_data = (int'(d) >= m_offset) ? int'(d) - m_offset : 0;
      if (clr) begin
        m_capturing    = 0;
        m_done_pending = 0;
        m_error        = 0;
        m_cal_valid    = 0;
        m_offset       = 0;
        m_quiet        = 0;
        m_samples.delete();
      end else if (m_done_pending) begin
        m_offset       = block_mean();
        m_cal_valid    = 1;
        m_error        = 0;
        m_done_pending = 0;
      end else if (m_capturing) begin
        if (v) begin
          m_samples.push_back(int'(d));
          m_quiet = 0;
          if (m_samples.size() == SETTLE_SAMPLES + AVG_N) begin
            m_capturing    = 0;
            m_done_pending = 1;
          end
        end else begin
          m_quiet++;
          if (m_quiet >= TIMEOUT_CYCLES) begin
            m_capturing = 0;
            m_error     = 1;
          end
        end
      end else if (cal) begin
        m_capturing = 1;
        m_quiet     = 0;
        m_samples.delete();
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({offset, cal_valid, busy, cal_error, corr_valid, corr_data} !==
        {DATA_W'(m_offset), m_cal_valid, m_capturing, m_error, m_corr_valid, DATA_W'(m_corr_data)}) begin
      n_errors++;
      $display("FAIL step @%0t: offset %0d/%0d cal_valid %0b/%0b busy %0b/%0b cal_error %0b/%0b corr_valid %0b/%0b corr_data %0d/%0d (got/expected)",
               $time, offset, m_offset, cal_valid, m_cal_valid, busy, m_capturing, cal_error, m_error,
               corr_valid, m_corr_valid, corr_data, m_corr_data);
    end
  endtask

  task automatic full_capture(input logic [DATA_W-1:0] value);
    step(1, 0, 0, 0);
    for (int i = 0; i < SETTLE_SAMPLES + AVG_N; i++) step(0, 0, 1, value);
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'($urandom), DATA_W'($urandom));
    n_checks++;
    if ({offset, cal_valid, busy, cal_error, corr_valid, corr_data} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got offset=%0d cal_valid=%0b busy=%0b cal_error=%0b corr_valid=%0b corr_data=%0d, expected all 0",
               offset, cal_valid, busy, cal_error, corr_valid, corr_data);
    end
    reset_n = 1'b1;
    step(0, 0, 0, 0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_pulse_ignored: busy got %0b expected 0", busy);
    end
  endtask

  task automatic test_nominal();
    step(1, 0, 0, 0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL nominal_busy_rise: got %0b expected 1", busy);
    end
    for (int i = 0; i < SETTLE_SAMPLES + AVG_N; i++) step(0, 0, 1, 16'd100);
    step(0, 0, 0, 0);
    n_checks++;
    if (offset !== 16'd100 || cal_valid !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL nominal_offset: got offset=%0d cal_valid=%0b busy=%0b expected 100/1/0", offset, cal_valid, busy);
    end
    step(0, 0, 1, 16'd350);
    n_checks++;
    if (corr_data !== 16'd250 || corr_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL nominal_corr: got %0d valid %0b expected 250 valid 1", corr_data, corr_valid);
    end
  endtask

  task automatic test_average();
    step(1, 0, 0, 0);
    for (int i = 0; i < SETTLE_SAMPLES; i++) step(0, 0, 1, 16'd9999);
    for (int i = 0; i < AVG_N; i++) step(0, 0, 1, (i % 2 == 1) ? 16'd11 : 16'd10);
    // This sample lands in the DONE cycle and must still use the old offset of 100.
    step(0, 0, 1, 16'd500);
    n_checks++;
    if (offset !== 16'd10 || corr_data !== 16'd400) begin
      n_errors++;
      $display("FAIL average_truncate: got offset=%0d corr=%0d expected 10/400", offset, corr_data);
    end
    step(0, 0, 1, 16'd500);
    n_checks++;
    if (corr_data !== 16'd490) begin
      n_errors++;
      $display("FAIL average_new_offset: got %0d expected 490", corr_data);
    end
  endtask

  task automatic test_saturation();
    full_capture(16'd100);
    step(0, 0, 1, 16'd40);
    n_checks++;
    if (corr_data !== 16'd0) begin
      n_errors++;
      $display("FAIL sat_low: got %0d expected 0", corr_data);
    end
    step(0, 0, 1, 16'hFFFF);
    n_checks++;
    if (corr_data !== 16'hFF9B) begin
      n_errors++;
      $display("FAIL sat_high: got %h expected ff9b", corr_data);
    end
    step(0, 0, 0, 16'd7);
    n_checks++;
    if (corr_data !== 16'hFF9B || corr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_hold: got %h valid %0b expected ff9b valid 0", corr_data, corr_valid);
    end
  endtask

  task automatic test_timeout();
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 16'd300);
    for (int i = 1; i <= TIMEOUT_CYCLES; i++) begin
      step(0, 0, 0, DATA_W'($urandom));
      n_checks++;
      if (cal_error !== (i == TIMEOUT_CYCLES) || busy !== (i != TIMEOUT_CYCLES)) begin
        n_errors++;
        $display("FAIL timeout_edge: clock %0d got cal_error=%0b busy=%0b expected %0b/%0b",
                 i, cal_error, busy, i == TIMEOUT_CYCLES, i != TIMEOUT_CYCLES);
      end
    end
    n_checks++;
    if (offset !== 16'd100 || cal_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_keep: got offset=%0d cal_valid=%0b expected 100/1", offset, cal_valid);
    end
    step(1, 0, 0, 0);
    n_checks++;
    if (cal_error !== 1'b1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL error_restart: got cal_error=%0b busy=%0b expected 1/1", cal_error, busy);
    end
    for (int i = 0; i < SETTLE_SAMPLES + AVG_N; i++) step(0, 0, 1, 16'd64);
    step(0, 0, 0, 0);
    n_checks++;
    if (cal_error !== 1'b0 || offset !== 16'd64) begin
      n_errors++;
      $display("FAIL error_recover: got cal_error=%0b offset=%0d expected 0/64", cal_error, offset);
    end
  endtask

  task automatic test_clear();
    step(1, 0, 0, 0);
    for (int i = 0; i < SETTLE_SAMPLES + 5; i++) step(0, 0, 1, 16'd200);
    step(1, 0, 1, 16'd200);   // pulse mid-ACCUM is ignored, sample still counts
    for (int i = 0; i < AVG_N - 6; i++) step(0, 0, 1, 16'd200);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ignore_pulse_done: busy got %0b expected 0", busy);
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (offset !== 16'd200) begin
      n_errors++;
      $display("FAIL ignore_pulse_offset: got %0d expected 200", offset);
    end
    step(1, 1, 0, 0);
    n_checks++;
    if (offset !== 16'd0 || cal_valid !== 1'b0 || busy !== 1'b0 || cal_error !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_priority: got offset=%0d cal_valid=%0b busy=%0b cal_error=%0b expected all 0",
               offset, cal_valid, busy, cal_error);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'd5);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_no_capture: busy got %0b expected 0", busy);
    end
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 16'd77);
    step(0, 1, 0, 0);
    for (int i = 0; i < SETTLE_SAMPLES + AVG_N; i++) step(0, 0, 1, 16'd77);
    step(0, 0, 0, 0);
    n_checks++;
    if (offset !== 16'd0 || cal_valid !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_abort: got offset=%0d cal_valid=%0b busy=%0b expected 0/0/0", offset, cal_valid, busy);
    end
  endtask

  task automatic test_mid_reset();
    full_capture(16'd123);
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 16'd900);
    reset_n = 1'b0;
    step(0, 0, 1, 16'd900);
    reset_n = 1'b1;
    n_checks++;
    if ({offset, cal_valid, busy, cal_error, corr_valid, corr_data} !== '0) begin
      n_errors++;
      $display("FAIL mid_reset: got offset=%0d cal_valid=%0b busy=%0b cal_error=%0b corr=%0d expected all 0",
               offset, cal_valid, busy, cal_error, corr_data);
    end
    for (int i = 0; i < AVG_N; i++) step(0, 0, 1, 16'd900);
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 399) begin
        for (int q = 0; q < TIMEOUT_CYCLES + 10; q++) step(0, 0, 0, DATA_W'($urandom));
      end else begin
        step(($urandom % 30) == 0, ($urandom % 250) == 0, ($urandom % 4) != 0,
             DATA_W'($urandom_range(0, 65535)));
      end
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    cal_pulse    = 1'b0;
    clr_pulse    = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    model_reset();
    test_reset();
    test_nominal();
    test_average();
    test_saturation();
    test_timeout();
    test_clear();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cal_offset_sequencer.md
# cal_offset_sequencer

Calibration controller for the measurement datapath. It consumes the one-clock calibration pulse produced by the debounced pushbutton pulse generator. It then runs a zero-offset capture: discard settling samples, average a power-of-two block of ADC samples, and store the result as the offset. It also applies the stored offset to the live sample stream with a saturating subtract before the data goes on to averaging and display.

## Interface

Parameters:
- `DATA_W`, 16, width of ADC samples, the offset and the corrected samples.
- `AVG_LOG2`, 4, log2 of the number of samples averaged per capture (16).
- `SETTLE_SAMPLES`, 4, number of valid samples discarded after the pulse, before accumulation starts.
- `TIMEOUT_CYCLES`, 1_000_000, maximum clocks allowed between valid samples while a capture is in progress.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `cal_pulse`  in  1  one-clock request to start a capture.
- `clr_pulse`  in  1  one-clock request to clear the calibration.
- `sample_valid`  in  1  qualifies `sample_data`.
- `sample_data`  in  DATA_W  raw unsigned ADC sample.
- `offset`  out  DATA_W  current stored offset.
- `cal_valid`  out  1  a capture has completed since the last reset or clear.
- `busy`  out  1  high in SETTLE and ACCUM.
- `cal_error`  out  1  sticky timeout flag.
- `corr_valid`  out  1  `sample_valid` delayed by one clock.
- `corr_data`  out  DATA_W  the saturating result of `sample_data` minus `offset`, registered.

## Operation

States are IDLE, SETTLE, ACCUM, DONE and ERROR.

- **IDLE**
  - `cal_pulse` goes to SETTLE.
  - On entry to SETTLE, the settle counter and timeout counter are zeroed.
- **SETTLE**
  - Each `sample_valid` increments the settle counter.
  - After `SETTLE_SAMPLES` valid samples, go to ACCUM. The accumulator and sample counter are zeroed.
  - If `SETTLE_SAMPLES` is 0, go directly to ACCUM.
- **ACCUM**
  - Each valid sample is added into an accumulator of DATA_W+AVG_LOG2 bits, so it never overflows.
  - When the 2^AVG_LOG2-th sample is added, go to DONE.
- **DONE** (exactly one cycle)
  - `offset` is loaded with `acc >> AVG_LOG2` (truncating).
  - `cal_valid` is set to 1 and `cal_error` is cleared.
  - Return to IDLE.
- **Timeout**
  - In SETTLE and ACCUM, the timeout counter counts clocks and resets to 0 on every `sample_valid`.
  - When it reaches `TIMEOUT_CYCLES` with no valid sample, go to ERROR.
  - `offset` and `cal_valid` are left unchanged.
- **ERROR**
  - `cal_error` is 1.
  - `cal_pulse` starts a new capture (go to SETTLE).
  - `cal_error` stays set until that capture reaches DONE or `clr_pulse` arrives.

Event rules:
- `cal_pulse` in SETTLE, ACCUM or DONE is ignored; there is no restart.
- `clr_pulse` in any state:
  - go to IDLE;
  - `offset` becomes 0, `cal_valid` becomes 0, `cal_error` becomes 0;
  - the counters and accumulator are zeroed.
- `clr_pulse` has priority over a `cal_pulse` in the same cycle.
- `clr_pulse` during a capture aborts it.

Correction path:
- It runs in every state.
- `corr_data` is `sample_data - offset` when `sample_data >= offset`, else 0.
- `corr_data` holds its value when `sample_valid` is 0.
- Samples are corrected with the offset value that is registered in the cycle they arrive. A sample arriving in the DONE cycle therefore uses the old offset.

## Timing

- Reset (`reset_n` low on a rising edge):
  - state IDLE;
  - `offset` = 0, `cal_valid` = 0, `busy` = 0, `cal_error` = 0;
  - `corr_valid` = 0, `corr_data` = 0;
  - all counters and the accumulator cleared.
- Reset asserted mid-capture aborts the capture identically to reset from idle.
- `busy` is registered:
  - it rises the clock after the accepted `cal_pulse`;
  - it falls on entry to DONE.
- `offset` and `cal_valid` update on the clock edge that leaves DONE.
- Capture latency from the accepted pulse to `offset` valid is SETTLE + ACCUM + DONE: `SETTLE_SAMPLES + 2^AVG_LOG2` valid samples, plus 2 clocks.
- Correction latency is 1 clock, at full throughput. `sample_valid` may be high every cycle.
- The timeout compare is `>=`, so ERROR is entered exactly `TIMEOUT_CYCLES` clocks after the last valid sample.

## Structure

- Package `cal_pkg` holds:
  - the `cal_state_t` enum (IDLE, SETTLE, ACCUM, DONE, ERROR);
  - the counter-width localparam helpers, using `$clog2` of `TIMEOUT_CYCLES+1` and `SETTLE_SAMPLES+1`.
- Sub-module `cal_offset_corrector` holds the registered saturating subtract and the valid delay. It takes `clk`, `reset_n`, `sample_valid`, `sample_data` and `offset`.
- The top level holds the FSM, the counters, the accumulator and the offset register.
- The button pulse generator is instantiated outside this block and drives `cal_pulse`.

## Test plan

- **Reset defaults:** hold `reset_n`=0 for 3 clocks with random inputs → every output is 0; `cal_pulse` during reset is ignored.
- **Nominal capture:** defaults; pulse, then 20 valid samples of 100 → `busy` for the capture, `offset`=100, `cal_valid`=1. A subsequent sample of 350 gives `corr_data`=250 one clock later.
- **Averaging and truncation:**
  - 4 settle samples of 9999, then 16 samples alternating 10 and 11 → `offset`=10 (168/16 truncated);
  - settle samples are not included.
- **Saturation:** `offset`=100, input 40 → `corr_data`=0; input 0xFFFF → 0xFF9B.
- **Timeout:** `TIMEOUT_CYCLES`=50; pulse, 6 samples, then silence → ERROR exactly 50 clocks after the 6th sample. `cal_error`=1, `offset` unchanged; a new pulse with a full capture clears `cal_error`.
- **Clear and collisions:**
  - `cal_pulse` mid-ACCUM is ignored;
  - `clr_pulse` together with `cal_pulse` gives IDLE, `offset`=0, `cal_valid`=0 and no capture started.
